// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point FFT/IFFT datapath.
// Holds the default frame geometry, the complex sample type, the
// collector's writer state encoding and the bit-reversal helper that the
// transform core and the frame collector both use.
package fft_pkg;

  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int WIDTH = 16;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_FILL = 1'b1
  } wr_state_e;

  // Reverse the low 'bits' bits of x; bits above that come back zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int bits);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < bits) r[5'(bits - 1 - b)] = x[5'(b)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// Two-bank sample store for the frame collector.
// Ports:
//   clk, reset     clock, async active-low reset (clears contents)
//   we, wr_bank,   single write port: bank select, word address, data
//   wr_addr, wr_data
//   rd_bank,       combinational read port: bank select, word address
//   rd_addr, rd_data
module fft_pingpong_bank #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [LOG2N-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_bank,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [DW-1:0]    rd_data
);

  logic [1:0][N-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  mem_q <= '0;
    else if (we) mem_q[wr_bank][wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_bank][rd_addr];

endmodule

// File: rtl/fft_frame_collector.sv
// Output-side frame collector for the FFT core.
// Captures frames arriving in (optionally) bit-reversed order into a
// ping-pong store and replays them in natural bin order over valid/ready.
// The core cannot be stalled: a frame that finds its target bank still
// full is dropped and the sticky overflow flag is raised.
// Ports:
//   clk, reset                  clock, async active-low reset
//   data_real_in/data_imag_in   sample from the core
//   in_valid, in_start          sample qualifier, first-sample marker
//   out_real/out_imag/out_index natural-order sample and its bin index
//   out_last                    high on bin N-1
//   out_valid/out_ready         downstream handshake
//   overflow                    sticky: at least one frame dropped
module fft_frame_collector #(
  parameter int N      = fft_pkg::N,
  parameter int LOG2N  = fft_pkg::LOG2N,
  parameter int WIDTH  = fft_pkg::WIDTH,
  parameter int BITREV = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] data_real_in,
  input  logic signed [WIDTH-1:0] data_imag_in,
  input  logic                    in_valid,
  input  logic                    in_start,
  output logic signed [WIDTH-1:0] out_real,
  output logic signed [WIDTH-1:0] out_imag,
  output logic [LOG2N-1:0]        out_index,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
);
  import fft_pkg::*;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

  // writer
  wr_state_e        wr_state_q, wr_state_d;
  logic             wr_bank_q, wr_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       full_q, full_d;
  logic             we, full_set;
  logic [LOG2N-1:0] wr_pos, wr_addr;
  logic [31:0]      wr_pos_br;

  // reader
  logic               rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]   rd_cnt_q, rd_cnt_d;
  logic               vld_q, vld_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic               hs, full_clr, load;
  logic               rd_sel_bank;
  logic [LOG2N-1:0]   rd_addr;
  logic [2*WIDTH-1:0] rd_data;

  // Writer next state. in_start wins over everything and restarts the frame,
  // silently abandoning any partial frame (its bank was never marked full).
  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    wr_cnt_d   = wr_cnt_q;
    drop_d     = drop_q;
    ovf_d      = ovf_q;
    we         = 1'b0;
    full_set   = 1'b0;
    wr_pos     = wr_cnt_q;
    if (in_valid && in_start) begin
      wr_pos     = '0;
      wr_cnt_d   = ONE;
      wr_state_d = WR_FILL;
      if (full_q[wr_bank_q]) begin
        drop_d = 1'b1;
        ovf_d  = 1'b1;
      end else begin
        drop_d = 1'b0;
        we     = 1'b1;
      end
    end else if (in_valid && wr_state_q == WR_FILL) begin
      we       = !drop_q;
      wr_cnt_d = wr_cnt_q + ONE;
      if (wr_cnt_q == LAST) begin
        full_set   = !drop_q;
        wr_bank_d  = drop_q ? wr_bank_q : ~wr_bank_q;
        drop_d     = 1'b0;
        wr_cnt_d   = '0;
        wr_state_d = WR_IDLE;
      end
    end
  end

  assign wr_pos_br = bitrev(32'(wr_pos), LOG2N);
  assign wr_addr   = (BITREV != 0) ? wr_pos_br[LOG2N-1:0] : wr_pos;

  // Reader: the output register holds bin rd_cnt of bank rd_bank. On a
  // handshake the next word is fetched in the same edge, and after bin N-1
  // the other bank's bin 0 is fetched directly so full banks stream gaplessly.
  assign hs = vld_q && out_ready;

  always_comb begin
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    vld_d       = vld_q;
    full_clr    = 1'b0;
    load        = 1'b0;
    rd_sel_bank = rd_bank_q;
    rd_addr     = rd_cnt_q;
    if (hs && rd_cnt_q == LAST) begin
      full_clr    = 1'b1;
      rd_bank_d   = ~rd_bank_q;
      rd_cnt_d    = '0;
      rd_sel_bank = ~rd_bank_q;
      rd_addr     = '0;
      vld_d       = full_q[~rd_bank_q];
      load        = full_q[~rd_bank_q];
    end else if (hs) begin
      rd_cnt_d = rd_cnt_q + ONE;
      rd_addr  = rd_cnt_q + ONE;
      load     = 1'b1;
    end else if (!vld_q) begin
      // idle reader always sits at bin 0
      vld_d = full_q[rd_bank_q];
      load  = full_q[rd_bank_q];
    end
  end

  always_comb begin
    dout_d = load ? rd_data : dout_q;
  end

  // Writer and reader never target the same bank, so set and clear compose.
  always_comb begin
    full_d = full_q;
    if (full_set) full_d[wr_bank_q] = 1'b1;
    if (full_clr) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state_q <= WR_IDLE;
      wr_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      drop_q     <= 1'b0;
      ovf_q      <= 1'b0;
      full_q     <= 2'b00;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      vld_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_bank_q  <= wr_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      full_q     <= full_d;
      rd_bank_q  <= rd_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      vld_q      <= vld_d;
      dout_q     <= dout_d;
    end
  end

  fft_pingpong_bank #(
    .N    (N),
    .LOG2N(LOG2N),
    .DW   (2 * WIDTH)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .wr_bank(wr_bank_q),
    .wr_addr(wr_addr),
    .wr_data({data_real_in, data_imag_in}),
    .rd_bank(rd_sel_bank),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign out_real  = dout_q[2*WIDTH-1:WIDTH];
  assign out_imag  = dout_q[WIDTH-1:0];
  assign out_index = rd_cnt_q;
  assign out_valid = vld_q;
  assign out_last  = vld_q && (rd_cnt_q == LAST);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector (N=32, bit-reversed input).
module tb_fft_frame_collector;

  localparam int NP = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [15:0] din_re, din_im;
  logic               in_valid, in_start, out_ready;
  logic signed [15:0] out_real, out_imag;
  logic [4:0]         out_index;
  logic               out_last, out_valid, overflow;

  fft_frame_collector #(.N(32), .LOG2N(5), .WIDTH(16), .BITREV(1)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .data_real_in(din_re),
    .data_imag_in(din_im),
    .in_valid    (in_valid),
    .in_start    (in_start),
    .out_real    (out_real),
    .out_imag    (out_imag),
    .out_index   (out_index),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0, nfail = 0, cyc = 0, ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver: 0 = held high, 1 = toggling, 2 = held low
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic int br5(input int i);
    int r = 0;
    for (int b = 0; b < 5; b++) if ((i & (1 << b)) != 0) r |= 1 << (4 - b);
    return r;
  endfunction

  // Handshake log plus hold-stability check while stalled.
  int q_re[$], q_im[$], q_idx[$], q_last[$], q_cyc[$];
  logic pv = 1'b0, pr = 1'b0;
  int   pre, pim, pidx;

  always @(negedge clk) begin
    if (rst_n && pv && !pr) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_real", int'(out_real), pre);
      check("hold_imag", int'(out_imag), pim);
      check("hold_index", int'(out_index), pidx);
    end
    if (out_valid && out_ready) begin
      q_re.push_back(int'(out_real));
      q_im.push_back(int'(out_imag));
      q_idx.push_back(int'(out_index));
      q_last.push_back(int'(out_last));
      q_cyc.push_back(cyc);
    end
    pv = out_valid; pr = out_ready;
    pre = int'(out_real); pim = int'(out_imag); pidx = int'(out_index);
  end

  task automatic clr_q();
    q_re.delete(); q_im.delete(); q_idx.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic drive(input bit st, input int re, input int im);
    in_valid = 1'b1; in_start = st; din_re = 16'(re); din_im = 16'(im);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < NP; k++) drive(k == 0, base + k, -(base + k));
    in_valid = 1'b0; in_start = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget);
    int c = 0;
    while (q_re.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
  endtask

  task automatic check_frame(input int off, input int base);
    for (int i = 0; i < NP; i++) begin
      int e = base + br5(i);
      if (off + i < q_re.size()) begin
        check($sformatf("re[%0d]", off + i), q_re[off + i], e);
        check($sformatf("im[%0d]", off + i), q_im[off + i], -e);
        check($sformatf("idx[%0d]", off + i), q_idx[off + i], i);
        check($sformatf("last[%0d]", off + i), q_last[off + i], (i == NP - 1) ? 1 : 0);
      end else begin
        check($sformatf("missing[%0d]", off + i), q_re.size(), off + i + 1);
      end
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_index", int'(out_index), 0);
    check("rst_real", int'(out_real), 0);
    check("rst_imag", int'(out_imag), 0);
    check("rst_overflow", int'(overflow), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_q();
  endtask

  typedef struct {
    int base;     // sample k of the frame is (base+k, -(base+k))
    int mode;     // out_ready pattern
    int exp_lat;  // negedges from end of frame to first out_valid
    int exp_n;    // outputs delivered
    int exp_ovf;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int n;
    in_valid = 1'b0; in_start = 1'b0; din_re = '0; din_im = '0;
    tbl[0] = '{0,     0, 2, 32, 0};
    tbl[1] = '{100,   1, 2, 32, 0};
    tbl[2] = '{-300,  0, 2, 32, 0};
    tbl[3] = '{32000, 1, 2, 32, 0};

    #2;
    do_reset();

    // single frames, various data and ready patterns
    for (int v = 0; v < 4; v++) begin
      clr_q();
      ready_mode = tbl[v].mode;
      send_frame(tbl[v].base);
      n = 0;
      while (!out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("latency[%0d]", v), n, tbl[v].exp_lat);
      wait_q(tbl[v].exp_n, 200);
      repeat (5) @(negedge clk);
      #1;
      check($sformatf("count[%0d]", v), q_re.size(), tbl[v].exp_n);
      check_frame(0, tbl[v].base);
      check($sformatf("ovf[%0d]", v), int'(overflow), tbl[v].exp_ovf);
    end

    // back-to-back frames stream without a bubble
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    clr_q();
    send_frame(200);
    send_frame(300);
    wait_q(64, 300);
    check("b2b_count", q_re.size(), 64);
    check_frame(0, 200);
    check_frame(32, 300);
    for (int i = 1; i < 64 && i < q_cyc.size(); i++)
      check($sformatf("b2b_gap[%0d]", i), q_cyc[i] - q_cyc[i - 1], 1);

    // stalled consumer: two frames held, third dropped
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    clr_q();
    send_frame(400);
    send_frame(500);
    check("ovf_before_drop", int'(overflow), 0);
    drive(1'b1, 600, -600);
    check("ovf_on_drop", int'(overflow), 1);
    for (int k = 1; k < NP; k++) drive(1'b0, 600 + k, -(600 + k));
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("stall_no_output", q_re.size(), 0);
    ready_mode = 0;
    wait_q(64, 300);
    repeat (40) @(negedge clk);
    #1;
    check("drop_count", q_re.size(), 64);
    check_frame(0, 400);
    check_frame(32, 500);
    check("ovf_sticky", int'(overflow), 1);

    // restarted frame: only the second one comes out
    do_reset();
    ready_mode = 0;
    for (int k = 0; k < 10; k++) drive(k == 0, 700 + k, -(700 + k));
    send_frame(800);
    wait_q(32, 200);
    repeat (40) @(negedge clk);
    #1;
    check("restart_count", q_re.size(), 32);
    check_frame(0, 800);
    check("restart_ovf", int'(overflow), 0);

    // reset in the middle of readout
    clr_q();
    send_frame(900);
    n = 0;
    while (!(out_valid && out_index == 5'd15) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx15", int'(out_index), 15);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_index", int'(out_index), 0);
    check("midrst_real", int'(out_real), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_q();
    repeat (60) @(negedge clk);
    #1;
    check("postrst_silent", q_re.size(), 0);
    check("postrst_valid", int'(out_valid), 0);
    send_frame(1100);
    wait_q(32, 200);
    repeat (5) @(negedge clk);
    #1;
    check("postrst_count", q_re.size(), 32);
    check_frame(0, 1100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
